// File: rtl/ksa_sched_pkg.sv
// ksa_sched_pkg
// Shared types, defaults and helpers for the RC4 key-search scheduler.
//   state_t      : scheduler FSM encoding
//   KEY_W_DEFAULT, KEY_MAX_DEFAULT : default key-space geometry
//   chunk_limit(): last key of a chunk, clipped to the end of the key space
package ksa_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        SUCCESS = 2'd2,
        FAIL    = 2'd3
    } state_t;

    localparam int          KEY_W_DEFAULT   = 24;
    localparam logic [23:0] KEY_MAX_DEFAULT = 24'h3FFFFF;

    // Operates on 32-bit values so it serves any KEY_W up to 31 (next_base
    // carries one extra bit for overflow detection).
    function automatic logic [31:0] chunk_limit(input logic [31:0] base,
                                                input int          chunk_w,
                                                input logic [31:0] key_max);
        logic [31:0] last;
        last = base + ((32'd1 << chunk_w) - 32'd1);
        return (last > key_max) ? key_max : last;
    endfunction

endpackage

// File: rtl/ksa_rr_arbiter.sv
// ksa_rr_arbiter
// N-way round-robin picker: grants the first requester at or after ptr,
// wrapping around.
// Ports:
//   req   in  N      request vector (idle cores)
//   ptr   in  PTR_W  starting index of the search (must be < N)
//   grant out N      one-hot grant, zero when nothing requests
//   valid out 1      some request was granted
//   idx   out PTR_W  binary index of the granted requester
module ksa_rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             valid,
    output logic [PTR_W-1:0] idx
);

    always_comb begin
        int j;
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!valid && req[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                idx      = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/ksa_search_scheduler.sv
// ksa_search_scheduler
// Splits the key space 0..KEY_MAX into 2^CHUNK_W-key chunks, hands them
// round-robin to idle cracking cores, and reports the first hit or
// exhaustion of the key space.
// Ports:
//   CLOCK_50      in   system clock
//   reset_n       in   asynchronous active-low reset
//   start         in   one-cycle pulse, begins a new search (ignored while busy)
//   core_start    out  per-core dispatch pulse, chunk fields valid that cycle
//   core_base     out  first key of the dispatched chunk (KEY_W slice per core)
//   core_limit    out  last key (inclusive) of the dispatched chunk
//   core_abort    out  level, held in SUCCESS/FAIL so cores go idle
//   core_done     in   per-core chunk-finished pulse
//   core_found    in   qualifies core_done: key matched
//   core_key      in   matching key per core
//   busy          out  search in progress
//   found         out  sticky success flag
//   failed        out  sticky exhaustion flag
//   found_key     out  winning key, 0 until found
//   progress_key  out  base of the most recently dispatched chunk
// Optional (macro KSA_SCHED_STATS_EN):
//   chunks_done   out  saturating count of no-hit chunk completions
//   search_cycles out  cycles spent busy, frozen once the search ends
//
// state   | meaning
// IDLE    | after reset, waiting for start
// RUN     | dispatching chunks and collecting results (busy)
// SUCCESS | a core reported a hit; cores aborted
// FAIL    | key space exhausted without a hit; cores aborted
module ksa_search_scheduler
    import ksa_sched_pkg::*;
#(
    parameter int               N_CORES = 4,
    parameter int               KEY_W   = KEY_W_DEFAULT,
    parameter logic [KEY_W-1:0] KEY_MAX = KEY_W'(KEY_MAX_DEFAULT),
    parameter int               CHUNK_W = 16
) (
    input  logic                       CLOCK_50,
    input  logic                       reset_n,
    input  logic                       start,
    output logic [N_CORES-1:0]         core_start,
    output logic [N_CORES*KEY_W-1:0]   core_base,
    output logic [N_CORES*KEY_W-1:0]   core_limit,
    output logic                       core_abort,
    input  logic [N_CORES-1:0]         core_done,
    input  logic [N_CORES-1:0]         core_found,
    input  logic [N_CORES*KEY_W-1:0]   core_key,
    output logic                       busy,
    output logic                       found,
    output logic                       failed,
    output logic [KEY_W-1:0]           found_key,
    output logic [KEY_W-1:0]           progress_key
`ifdef KSA_SCHED_STATS_EN
    ,
    output logic [KEY_W-CHUNK_W:0]     chunks_done,
    output logic [31:0]                search_cycles
`endif
);

    localparam int             PTR_W      = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam logic [KEY_W:0] CHUNK_SIZE = {{KEY_W{1'b0}}, 1'b1} << CHUNK_W;
    localparam logic [KEY_W:0] KEY_END    = {1'b0, KEY_MAX};

    state_t             state, state_nxt;
    logic [N_CORES-1:0] owned;
    logic [KEY_W:0]     next_base;
    logic [PTR_W-1:0]   rr_ptr;

    logic [N_CORES-1:0] done_v;
    logic [N_CORES-1:0] hit_v;
    logic [N_CORES-1:0] owned_clr;
    logic               any_hit;
    logic               space_left;
    logic [KEY_W-1:0]   hit_key;
    logic [31:0]        limit_full;

    logic [N_CORES-1:0] grant;
    logic               arb_valid;
    logic [PTR_W-1:0]   arb_idx;
    logic [PTR_W-1:0]   rr_nxt;
    logic               dispatch;
    logic               restart;

    // Results only count from cores that actually hold a chunk.
    assign done_v     = core_done & owned;
    assign hit_v      = done_v & core_found;
    assign any_hit    = |hit_v;
    // A done in the same cycle frees the core before arbitration, so it can
    // be handed a new chunk immediately.
    assign owned_clr  = owned & ~core_done;
    assign space_left = (next_base <= KEY_END);
    assign limit_full = chunk_limit(32'(next_base), CHUNK_W, 32'(KEY_MAX));
    assign restart    = start && (state != RUN);

    ksa_rr_arbiter #(
        .N     (N_CORES),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (~owned_clr),
        .ptr   (rr_ptr),
        .grant (grant),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

    // A hit suppresses dispatch in the same cycle.
    assign dispatch = (state == RUN) && !any_hit && space_left && arb_valid;
    assign rr_nxt   = (arb_idx == PTR_W'(N_CORES - 1)) ? '0 : arb_idx + 1'b1;

    always_comb begin
        logic seen;
        hit_key = '0;
        seen    = 1'b0;
        for (int i = 0; i < N_CORES; i++) begin
            if (hit_v[i] && !seen) begin
                hit_key = core_key[i*KEY_W +: KEY_W];
                seen    = 1'b1;
            end
        end
    end

    always_comb begin
        core_start = '0;
        core_base  = '0;
        core_limit = '0;
        if (dispatch) begin
            core_start = grant;
            for (int i = 0; i < N_CORES; i++) begin
                if (grant[i]) begin
                    core_base[i*KEY_W +: KEY_W]  = next_base[KEY_W-1:0];
                    core_limit[i*KEY_W +: KEY_W] = limit_full[KEY_W-1:0];
                end
            end
        end
    end

    assign busy       = (state == RUN);
    assign core_abort = (state == SUCCESS) || (state == FAIL);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:          if (start) state_nxt = RUN;
            RUN: begin
                if (any_hit)                           state_nxt = SUCCESS;
                else if (!space_left && owned_clr == '0) state_nxt = FAIL;
            end
            SUCCESS, FAIL: if (start) state_nxt = RUN;
            default:       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            owned        <= '0;
            next_base    <= '0;
            rr_ptr       <= '0;
            found        <= 1'b0;
            failed       <= 1'b0;
            found_key    <= '0;
            progress_key <= '0;
        end else if (restart) begin
            owned        <= '0;
            next_base    <= '0;
            rr_ptr       <= '0;
            found        <= 1'b0;
            failed       <= 1'b0;
            found_key    <= '0;
            progress_key <= '0;
        end else if (state == RUN) begin
            if (any_hit) begin
                found     <= 1'b1;
                found_key <= hit_key;
                owned     <= '0;
            end else begin
                owned <= owned_clr | (dispatch ? grant : '0);
                if (dispatch) begin
                    progress_key <= next_base[KEY_W-1:0];
                    next_base    <= next_base + CHUNK_SIZE;
                    rr_ptr       <= rr_nxt;
                end
                if (state_nxt == FAIL) failed <= 1'b1;
            end
        end
    end

`ifdef KSA_SCHED_STATS_EN
    localparam int CD_W = KEY_W - CHUNK_W + 1;

    logic [CD_W-1:0] cd_q;
    logic [31:0]     cyc_q;
    logic [3:0]      miss_cnt;
    logic [CD_W+3:0] cd_sum;

    always_comb begin
        miss_cnt = '0;
        for (int i = 0; i < N_CORES; i++) begin
            miss_cnt = miss_cnt + {3'b000, done_v[i] & ~core_found[i]};
        end
        cd_sum = {4'b0000, cd_q} + {{CD_W{1'b0}}, miss_cnt};
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cd_q  <= '0;
            cyc_q <= '0;
        end else if (restart) begin
            cd_q  <= '0;
            cyc_q <= '0;
        end else if (state == RUN) begin
            cyc_q <= cyc_q + 32'd1;
            if (cd_sum > {4'b0000, {CD_W{1'b1}}}) cd_q <= {CD_W{1'b1}};
            else                                 cd_q <= cd_sum[CD_W-1:0];
        end
    end

    assign chunks_done   = cd_q;
    assign search_cycles = cyc_q;
`endif

endmodule
